uart_frame_check: RTL and testbench
===================================

# uart_frame_check

Parametrised receive-side frame checker for the UART RX path. It consumes one sampled bit per bit period from the data sampler and tracks the whole frame: start bit, data, optional parity, and one or two stop bits. At frame end it issues the data word together with registered start, parity, stop and break status. Saturating error counters feed the register file for low-power link monitoring.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- CNT_WIDTH, 8, width of each saturating error counter
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-low
- frame_start  in  1  one-cycle pulse from the RX FSM on a detected falling edge; ignored unless busy=0
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid for one bit period
- sampled_bit  in  1  majority-voted line value
- par_en  in  1  parity bit present; latched at frame_start
- par_type  in  1  0 = even, 1 = odd; latched at frame_start
- stop2  in  1  two stop bits when 1; latched at frame_start
- clr_err  in  1  synchronous clear of both counters
- busy  out  1  frame in progress
- data_out  out  DATA_WIDTH  received word, LSB-first assembly; held until the next good frame
- data_valid  out  1  one-cycle pulse for an error-free frame
- strt_glitch  out  1  one-cycle pulse when the start bit sampled high
- par_err  out  1  parity result of the last completed frame; held
- stp_err  out  1  stop result of the last completed frame; held
- break_det  out  1  one-cycle pulse on a break frame
- par_err_cnt  out  CNT_WIDTH  saturating count of frames with a parity error
- frm_err_cnt  out  CNT_WIDTH  saturating count of frames with a stop error

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: frame_start moves to START, latches config, and clears the bit counter and the parity accumulator.
- START: on bit_valid, sampled_bit=1 pulses strt_glitch and returns to IDLE. In that case par_err/stp_err are unchanged and no counter moves. sampled_bit=0 moves to DATA.
- DATA: each bit_valid shifts the bit in at MSB (right shift) and XORs it into the parity accumulator. After DATA_WIDTH bits, go to PARITY if par_en, else STOP1.
- PARITY: on bit_valid, expected bit = accumulator XOR par_type; a mismatch sets an internal parity flag. Go to STOP1.
- STOP1: on bit_valid, a low bit ends the frame with a stop error, even when stop2=1. A high bit goes to STOP2 if stop2, else ends the frame clean.
- STOP2: on bit_valid, the frame ends; a low bit is a stop error.
- Frame end (next cycle):
  - par_err and stp_err load the frame flags.
  - data_valid=1 and data_out update only if both flags are 0.
  - Each counter increments when its flag is set; both may increment in the same cycle.
  - Return to IDLE.
- Break: all data bits 0, parity bit 0 (if enabled) and STOP1 sampled 0. Pulse break_det with stp_err=1 and frm_err_cnt incrementing.
- Counters saturate at 2^CNT_WIDTH-1. clr_err wins over a simultaneous increment.
- bit_valid is ignored in IDLE. frame_start is ignored while busy.
- busy=1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, counters 0, state IDLE.
- RST asserted mid-frame aborts immediately. No pulse follows reset release.
- frame_start at edge n gives busy=1 from n+1.
- All status outputs are registered. Result outputs appear one cycle after the CLK edge that samples the final frame bit. Latency is therefore 1 cycle from the last bit_valid, with busy falling in the same cycle.
- strt_glitch asserts one cycle after the START bit_valid.
- A bit_valid coincident with frame_start (in IDLE) is not consumed.
- Back-to-back frames: frame_start is accepted in the cycle busy=0.

## Structure
- Package uart_frame_pkg: state enum; parity constants PAR_EVEN=0, PAR_ODD=1; DATA_WIDTH range checks.
- Sub-module err_sat_cnt (parameter CNT_WIDTH; ports inc, clr, cnt), instantiated twice.
- Everything else lives in one FSM plus a datapath.

## Test plan
- 8N1, data 0xA5, clean stop:
  - data_valid pulse with data_out=0xA5.
  - par_err=0, stp_err=0, counters 0.
  - Latency 1 cycle after the stop bit_valid.
- 8E1, data 0x07, parity bit sent 0 (expected 1):
  - par_err=1, par_err_cnt=1.
  - No data_valid; data_out keeps the previous value.
- 8O2, second stop bit 0:
  - stp_err=1, frm_err_cnt=1.
  - A following clean frame returns stp_err=0 and data_valid=1.
- Start bit sampled 1:
  - strt_glitch pulse, back to IDLE.
  - Status and counters unchanged.
- 8N1 all-zero line:
  - break_det pulse, stp_err=1, frm_err_cnt=1.
- Saturation and clear, with CNT_WIDTH=2:
  - 5 parity-error frames give par_err_cnt=3.
  - clr_err together with a 6th error frame gives 0.
  - RST mid-DATA returns busy=0 and all outputs 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART RX frame checker.
// Holds the FSM state encoding, parity-type codes and the legal data width range.
// Imported by the checker top and its error counter.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;

  function automatic bit dw_in_range(input int w);
    return (w >= DW_MIN) && (w <= DW_MAX);
  endfunction

endpackage

// File: rtl/err_sat_cnt.sv
// Saturating error event counter.
// Latency: count updates on the edge that samples inc; clr has priority over inc.
// No backpressure: holds at all-ones until cleared.
module err_sat_cnt
  import uart_frame_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  // Count events, stick at the maximum, clear synchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_check.sv
// UART RX frame checker: start/data/parity/stop tracking with break detection.
// Latency: results registered one cycle after the edge sampling the last frame bit.
// No backpressure: frame_start is dropped while busy, bit_valid is dropped in IDLE.
module uart_frame_check
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  input  logic                  clr_err,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  break_det,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  frm_err_cnt
);

  if (!dw_in_range(DATA_WIDTH)) begin : g_dw_check
    $error("uart_frame_check: DATA_WIDTH must be 5..9");
  end

  localparam int BW = $clog2(DATA_WIDTH);

  state_t                r_state;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_stop2;
  logic                  r_acc;
  logic                  r_par_flag;
  logic                  r_par_hi;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;

  logic w_end;
  logic w_stp_fail;
  logic w_brk;
  logic w_par_inc;
  logic w_frm_inc;

  // A frame ends on a low first stop bit (even with two stops configured),
  // on a high first stop bit with one stop, or on any second stop bit.
  assign w_end      = bit_valid &&
                      (((r_state == ST_STOP1) && (!sampled_bit || !r_stop2)) ||
                       (r_state == ST_STOP2));
  assign w_stp_fail = !sampled_bit;
  // Break only needs checking at STOP1: a line held low never reaches STOP2.
  assign w_brk      = (r_state == ST_STOP1) && (r_shift == '0) && !r_par_hi && w_stp_fail;
  assign w_par_inc  = w_end && r_par_flag;
  assign w_frm_inc  = w_end && w_stp_fail;
  assign busy       = (r_state != ST_IDLE);

  // Frame FSM with registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_par_en    <= 1'b0;
      r_par_type  <= PAR_EVEN;
      r_stop2     <= 1'b0;
      r_acc       <= 1'b0;
      r_par_flag  <= 1'b0;
      r_par_hi    <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      break_det   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state    <= ST_START;
            r_par_en   <= par_en;
            r_par_type <= par_type;
            r_stop2    <= stop2;
            r_bit_cnt  <= '0;
            r_acc      <= 1'b0;
            r_par_flag <= 1'b0;
            r_par_hi   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_valid) begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bit_valid) begin
            r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            r_acc     <= r_acc ^ sampled_bit;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            r_par_flag <= (sampled_bit != (r_acc ^ r_par_type));
            r_par_hi   <= sampled_bit;
            r_state    <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (bit_valid && sampled_bit && r_stop2) begin
            r_state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          r_state <= ST_STOP2;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // Frame end overrides the per-state transition above.
      if (w_end) begin
        r_state   <= ST_IDLE;
        par_err   <= r_par_flag;
        stp_err   <= w_stp_fail;
        break_det <= w_brk;
        if (!r_par_flag && !w_stp_fail) begin
          data_valid <= 1'b1;
          data_out   <= r_shift;
        end
      end
    end
  end

  err_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (w_par_inc),
    .clr (clr_err),
    .cnt (par_err_cnt)
  );

  err_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_frm_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (w_frm_inc),
    .clr (clr_err),
    .cnt (frm_err_cnt)
  );

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check (DATA_WIDTH=8, CNT_WIDTH=2).
// Inputs change on the falling edge; outputs are read on the falling edge.
// Status vector order: {busy, data_valid, strt_glitch, par_err, stp_err, break_det}.
module tb_uart_frame_check;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          frame_start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          par_en = 1'b0;
  logic          par_type = 1'b0;
  logic          stop2 = 1'b0;
  logic          clr_err = 1'b0;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic          break_det;
  logic [CW-1:0] par_err_cnt;
  logic [CW-1:0] frm_err_cnt;
  logic [5:0]    st;

  int n_cmp = 0;
  int n_fail = 0;

  assign st = {busy, data_valid, strt_glitch, par_err, stp_err, break_det};

  always #5 CLK = ~CLK;

  uart_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .sampled_bit (sampled_bit),
    .par_en      (par_en),
    .par_type    (par_type),
    .stop2       (stop2),
    .clr_err     (clr_err),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .break_det   (break_det),
    .par_err_cnt (par_err_cnt),
    .frm_err_cnt (frm_err_cnt)
  );

  // Called on a falling edge; returns on the next falling edge.
  task automatic start_frame(input logic pe, input logic pt, input logic s2);
    frame_start = 1'b1;
    par_en = pe;
    par_type = pt;
    stop2 = s2;
    @(negedge CLK);
    frame_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL start_busy: got %b want 1", busy);
      n_fail++;
    end
  endtask

  // seq[0] is sent first; returns on the falling edge right after the last bit is sampled.
  task automatic send_bits(input logic [15:0] seq, input int n, input logic clr_last);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bit_valid = 1'b1;
      sampled_bit = seq[i];
      if (i == n - 1) clr_err = clr_last;
      @(negedge CLK);
      bit_valid = 1'b0;
      clr_err = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({st, data_out, par_err_cnt, frm_err_cnt} !== '0) begin
      $display("FAIL reset_state: got st=%b d=%h pc=%0d fc=%0d want all 0", st, data_out, par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (st !== 6'b000000) begin
      $display("FAIL reset_release: got st=%b want 000000", st);
      n_fail++;
    end
  endtask

  task automatic test_8n1_clean;
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0);
    n_cmp++;
    if (st !== 6'b010000 || data_out !== 8'hA5) begin
      $display("FAIL 8n1_result: got st=%b d=%h want st=010000 d=a5", st, data_out);
      n_fail++;
    end
    n_cmp++;
    if (par_err_cnt !== 2'd0 || frm_err_cnt !== 2'd0) begin
      $display("FAIL 8n1_counts: got pc=%0d fc=%0d want 0 0", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    @(negedge CLK);
    n_cmp++;
    if (data_valid !== 1'b0) begin
      $display("FAIL 8n1_dv_pulse: got %b want 0", data_valid);
      n_fail++;
    end
  endtask

  task automatic test_8e1_parity;
    start_frame(1'b1, 1'b0, 1'b0);
    send_bits(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b0);
    n_cmp++;
    if (st !== 6'b000100 || data_out !== 8'hA5) begin
      $display("FAIL 8e1_result: got st=%b d=%h want st=000100 d=a5", st, data_out);
      n_fail++;
    end
    n_cmp++;
    if (par_err_cnt !== 2'd1 || frm_err_cnt !== 2'd0) begin
      $display("FAIL 8e1_counts: got pc=%0d fc=%0d want 1 0", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
  endtask

  task automatic test_8o2_stop;
    start_frame(1'b1, 1'b1, 1'b1);
    send_bits(16'({1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}), 12, 1'b0);
    n_cmp++;
    if (st !== 6'b000010 || data_out !== 8'hA5) begin
      $display("FAIL 8o2_result: got st=%b d=%h want st=000010 d=a5", st, data_out);
      n_fail++;
    end
    n_cmp++;
    if (par_err_cnt !== 2'd1 || frm_err_cnt !== 2'd1) begin
      $display("FAIL 8o2_counts: got pc=%0d fc=%0d want 1 1", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
  endtask

  task automatic test_start_glitch;
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'h0001, 1, 1'b0);
    n_cmp++;
    if (st !== 6'b001010 || data_out !== 8'hA5) begin
      $display("FAIL glitch_result: got st=%b d=%h want st=001010 d=a5", st, data_out);
      n_fail++;
    end
    n_cmp++;
    if (par_err_cnt !== 2'd1 || frm_err_cnt !== 2'd1) begin
      $display("FAIL glitch_counts: got pc=%0d fc=%0d want 1 1", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    @(negedge CLK);
    n_cmp++;
    if (st !== 6'b000010) begin
      $display("FAIL glitch_pulse: got st=%b want 000010", st);
      n_fail++;
    end
  endtask

  task automatic test_recover_clean;
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'({1'b1, 8'h5A, 1'b0}), 10, 1'b0);
    n_cmp++;
    if (st !== 6'b010000 || data_out !== 8'h5A) begin
      $display("FAIL recover_result: got st=%b d=%h want st=010000 d=5a", st, data_out);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'({1'b1, 8'h81, 1'b0}), 10, 1'b0);
    n_cmp++;
    if (st !== 6'b010000 || data_out !== 8'h81) begin
      $display("FAIL b2b_first: got st=%b d=%h want st=010000 d=81", st, data_out);
      n_fail++;
    end
    // Start on the very cycle busy is low, with a stray high bit strobe alongside.
    bit_valid = 1'b1;
    sampled_bit = 1'b1;
    start_frame(1'b0, 1'b0, 1'b0);
    bit_valid = 1'b0;
    n_cmp++;
    if (strt_glitch !== 1'b0) begin
      $display("FAIL b2b_coincident_bit: got strt_glitch=%b want 0", strt_glitch);
      n_fail++;
    end
    send_bits(16'({1'b1, 8'h3E, 1'b0}), 10, 1'b0);
    n_cmp++;
    if (st !== 6'b010000 || data_out !== 8'h3E) begin
      $display("FAIL b2b_second: got st=%b d=%h want st=010000 d=3e", st, data_out);
      n_fail++;
    end
  endtask

  task automatic test_break;
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    n_cmp++;
    if (par_err_cnt !== 2'd0 || frm_err_cnt !== 2'd0) begin
      $display("FAIL clr_counts: got pc=%0d fc=%0d want 0 0", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'h0000, 10, 1'b0);
    n_cmp++;
    if (st !== 6'b000011 || data_out !== 8'h3E) begin
      $display("FAIL break_result: got st=%b d=%h want st=000011 d=3e", st, data_out);
      n_fail++;
    end
    n_cmp++;
    if (par_err_cnt !== 2'd0 || frm_err_cnt !== 2'd1) begin
      $display("FAIL break_counts: got pc=%0d fc=%0d want 0 1", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 5; k++) begin
      start_frame(1'b1, 1'b0, 1'b0);
      send_bits(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b0);
    end
    n_cmp++;
    if (par_err_cnt !== 2'd3 || frm_err_cnt !== 2'd1) begin
      $display("FAIL sat_counts: got pc=%0d fc=%0d want 3 1", par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    start_frame(1'b1, 1'b0, 1'b0);
    send_bits(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b1);
    n_cmp++;
    if (par_err_cnt !== 2'd0 || frm_err_cnt !== 2'd0 || par_err !== 1'b1) begin
      $display("FAIL sat_clear: got pc=%0d fc=%0d pe=%b want 0 0 1", par_err_cnt, frm_err_cnt, par_err);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame;
    start_frame(1'b0, 1'b0, 1'b0);
    send_bits(16'h000E, 4, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL mid_busy: got %b want 1", busy);
      n_fail++;
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({st, data_out, par_err_cnt, frm_err_cnt} !== '0) begin
      $display("FAIL mid_reset: got st=%b d=%h pc=%0d fc=%0d want all 0", st, data_out, par_err_cnt, frm_err_cnt);
      n_fail++;
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (st !== 6'b000000 || data_out !== 8'h00) begin
      $display("FAIL mid_release: got st=%b d=%h want 000000 00", st, data_out);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_8n1_clean();
    test_8e1_parity();
    test_8o2_stop();
    test_start_glitch();
    test_recover_clean();
    test_back_to_back();
    test_break();
    test_saturation();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
